// File: rtl/mc_core_pkg.sv
// Shared definitions for the mc_core microcontroller: instruction fields,
// opcodes, FSM states and small arithmetic helpers.
package mc_core_pkg;

   localparam int OP_MSB = 15;
   localparam int OP_LSB = 11;
   localparam int RD_MSB = 10;
   localparam int RD_LSB = 8;
   localparam int RS_MSB = 7;
   localparam int RS_LSB = 5;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;
   localparam logic [2:0] LINK_REG = 3'd7;

   typedef enum logic [4:0] {
      OP_ADD    = 5'd0,
      OP_SUB    = 5'd1,
      OP_ADDI   = 5'd2,
      OP_SHLLI  = 5'd3,
      OP_SHRLI  = 5'd4,
      OP_JUMP   = 5'd5,
      OP_JUMPLI = 5'd6,
      OP_JUMPL  = 5'd7,
      OP_JUMPG  = 5'd8,
      OP_JUMPE  = 5'd9,
      OP_JUMPNE = 5'd10,
      OP_CMP    = 5'd11,
      OP_RET    = 5'd12,
      OP_LOAD   = 5'd13,
      OP_LOADI  = 5'd14,
      OP_STORE  = 5'd15,
      OP_MOV    = 5'd16
   } opcode_e;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXECUTE,
      ST_LOAD1,
      ST_LOAD2,
      ST_STORE1,
      ST_STORE2,
      ST_HALT
   } state_e;

   function automatic logic op_is_legal(input logic [4:0] op);
      return op <= OP_MOV;
   endfunction

   // Signed overflow of a + b from the operand and result sign bits.
   // For a subtraction pass the inverted sign of the subtrahend.
   function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
      return (a_msb == b_msb) && (r_msb != a_msb);
   endfunction

endpackage

// File: rtl/mc_regfile.sv
// Eight-entry register file: two combinational read ports, one write port
// committed on the rising clock edge, so a same-cycle read sees the old value.
module mc_regfile
   import mc_core_pkg::*;
#(
   parameter int DATA_W = 24
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [2:0]        ra_addr_i,
   output logic [DATA_W-1:0] ra_data_o,
   input  logic [2:0]        rb_addr_i,
   output logic [DATA_W-1:0] rb_data_o,
   input  logic              wr_en_i,
   input  logic [2:0]        wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i
);

   logic [DATA_W-1:0] regs_q [8];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_en_i) begin
         regs_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign ra_data_o = regs_q[ra_addr_i];
   assign rb_data_o = regs_q[rb_addr_i];

endmodule

// File: rtl/mc_core.sv
// Multi-cycle 16-bit-instruction core: FETCH/DECODE/EXECUTE with separate
// load and store phases on a single request/ready memory port.
module mc_core
   import mc_core_pkg::*;
#(
   parameter int                DATA_W   = 24,
   parameter int                ADDR_W   = 24,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [15:0]       mem_to_core_data,
   input  logic              mem_to_core_ready,
   output logic              core_to_mem_req,
   output logic [ADDR_W-1:0] core_to_mem_addr,
   output logic [15:0]       core_to_mem_data,
   output logic              core_to_mem_write_enable,
   output logic              halted,
   output logic [ADDR_W-1:0] dbg_pc
);

   state_e            state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] addr_q;
   logic [15:0]       instr_q;
   logic [15:0]       ld_data_q;
   logic [15:0]       wdata_q;
   logic [DATA_W-1:0] rd_val_q;
   logic [DATA_W-1:0] rs_val_q;
   logic              zf_q;
   logic              sf_q;
   logic              of_q;
   logic              req_q;
   logic              we_q;
   logic              halted_q;

   logic [4:0]        op;
   logic [2:0]        rd_idx;
   logic [2:0]        rs_idx;
   logic [7:0]        imm8;

   logic [2:0]        rf_ra_addr;
   logic [DATA_W-1:0] rf_ra_data;
   logic [DATA_W-1:0] rf_rb_data;
   logic              rf_wr_en;
   logic [2:0]        rf_wr_addr;
   logic [DATA_W-1:0] rf_wr_data;

   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] pc_rel;
   logic [ADDR_W-1:0] pc_d;
   logic [DATA_W-1:0] imm_ext;
   logic [DATA_W-1:0] sum_res;
   logic [DATA_W-1:0] dif_res;
   logic [DATA_W-1:0] addi_res;
   logic [DATA_W-1:0] shl_res;
   logic [DATA_W-1:0] shr_res;
   logic              lt;
   logic              wb_en;
   logic [2:0]        wb_idx;
   logic [DATA_W-1:0] wb_val;
   logic              flag_en;
   logic [DATA_W-1:0] flag_res;
   logic              flag_ovf;

   assign op     = instr_q[OP_MSB:OP_LSB];
   assign rd_idx = instr_q[RD_MSB:RD_LSB];
   assign rs_idx = instr_q[RS_MSB:RS_LSB];
   assign imm8   = instr_q[IMM_MSB:IMM_LSB];

   // RET needs R7, so port A is steered to the link register for it.
   assign rf_ra_addr = (op == OP_RET) ? LINK_REG : rd_idx;

   mc_regfile #(
      .DATA_W (DATA_W)
   ) u_regfile (
      .clk       (clk),
      .rst_n     (rst_n),
      .ra_addr_i (rf_ra_addr),
      .ra_data_o (rf_ra_data),
      .rb_addr_i (rs_idx),
      .rb_data_o (rf_rb_data),
      .wr_en_i   (rf_wr_en),
      .wr_addr_i (rf_wr_addr),
      .wr_data_i (rf_wr_data)
   );

   always_comb begin
      pc_inc   = pc_q + ADDR_W'(1);
      pc_rel   = pc_inc + ADDR_W'($signed(imm8));
      imm_ext  = DATA_W'($signed(imm8));
      sum_res  = rd_val_q + rs_val_q;
      dif_res  = rd_val_q - rs_val_q;
      addi_res = rd_val_q + imm_ext;
      shl_res  = (int'(imm8[4:0]) >= DATA_W) ? '0 : (rd_val_q << imm8[4:0]);
      shr_res  = (int'(imm8[4:0]) >= DATA_W) ? '0 : (rd_val_q >> imm8[4:0]);
      lt       = sf_q ^ of_q;
      pc_d     = pc_inc;
      wb_en    = 1'b0;
      wb_idx   = rd_idx;
      wb_val   = '0;
      flag_en  = 1'b0;
      flag_res = dif_res;
      flag_ovf = add_ovf(rd_val_q[DATA_W-1], ~rs_val_q[DATA_W-1], dif_res[DATA_W-1]);
      case (op)
         OP_ADD: begin
            wb_en    = 1'b1;
            wb_val   = sum_res;
            flag_en  = 1'b1;
            flag_res = sum_res;
            flag_ovf = add_ovf(rd_val_q[DATA_W-1], rs_val_q[DATA_W-1], sum_res[DATA_W-1]);
         end
         OP_SUB: begin
            wb_en   = 1'b1;
            wb_val  = dif_res;
            flag_en = 1'b1;
         end
         OP_ADDI: begin
            wb_en    = 1'b1;
            wb_val   = addi_res;
            flag_en  = 1'b1;
            flag_res = addi_res;
            flag_ovf = add_ovf(rd_val_q[DATA_W-1], imm_ext[DATA_W-1], addi_res[DATA_W-1]);
         end
         OP_CMP:    flag_en = 1'b1;
         OP_SHLLI: begin
            wb_en  = 1'b1;
            wb_val = shl_res;
         end
         OP_SHRLI: begin
            wb_en  = 1'b1;
            wb_val = shr_res;
         end
         OP_MOV: begin
            wb_en  = 1'b1;
            wb_val = rs_val_q;
         end
         OP_JUMP: pc_d = ADDR_W'(rs_val_q);
         OP_JUMPLI: begin
            wb_en  = 1'b1;
            wb_idx = LINK_REG;
            wb_val = DATA_W'(pc_inc);
            pc_d   = pc_rel;
         end
         OP_JUMPL:  pc_d = lt ? pc_rel : pc_inc;
         OP_JUMPG:  pc_d = (!zf_q && !lt) ? pc_rel : pc_inc;
         OP_JUMPE:  pc_d = zf_q ? pc_rel : pc_inc;
         OP_JUMPNE: pc_d = !zf_q ? pc_rel : pc_inc;
         OP_RET:    pc_d = ADDR_W'(rd_val_q);
         default:   ;
      endcase
   end

   assign rf_wr_en   = ((state_q == ST_EXECUTE) && wb_en) || (state_q == ST_LOAD2);
   assign rf_wr_addr = (state_q == ST_LOAD2) ? rd_idx : wb_idx;
   assign rf_wr_data = (state_q == ST_LOAD2) ? DATA_W'(ld_data_q) : wb_val;

   // Memory request outputs are registered: each transition into a request
   // state loads req/addr/we/data, which then hold until ready is seen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_FETCH;
         pc_q      <= RESET_PC;
         addr_q    <= RESET_PC;
         instr_q   <= '0;
         ld_data_q <= '0;
         wdata_q   <= '0;
         rd_val_q  <= '0;
         rs_val_q  <= '0;
         zf_q      <= 1'b0;
         sf_q      <= 1'b0;
         of_q      <= 1'b0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         halted_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_FETCH: begin
               if (!req_q) begin
                  req_q  <= 1'b1;
                  we_q   <= 1'b0;
                  addr_q <= pc_q;
               end else if (mem_to_core_ready) begin
                  instr_q <= mem_to_core_data;
                  req_q   <= 1'b0;
                  state_q <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               rd_val_q <= rf_ra_data;
               rs_val_q <= rf_rb_data;
               case (op)
                  OP_LOAD, OP_LOADI: begin
                     req_q   <= 1'b1;
                     we_q    <= 1'b0;
                     addr_q  <= (op == OP_LOAD) ? ADDR_W'(rf_rb_data) : ADDR_W'(imm8);
                     state_q <= ST_LOAD1;
                  end
                  OP_STORE: begin
                     req_q   <= 1'b1;
                     we_q    <= 1'b1;
                     addr_q  <= ADDR_W'(rf_rb_data);
                     wdata_q <= rf_ra_data[15:0];
                     state_q <= ST_STORE1;
                  end
                  default: begin
                     if (op_is_legal(op)) begin
                        state_q <= ST_EXECUTE;
                     end else begin
                        halted_q <= 1'b1;
                        state_q  <= ST_HALT;
                     end
                  end
               endcase
            end
            ST_EXECUTE: begin
               if (flag_en) begin
                  zf_q <= (flag_res == '0);
                  sf_q <= flag_res[DATA_W-1];
                  of_q <= flag_ovf;
               end
               pc_q    <= pc_d;
               req_q   <= 1'b1;
               we_q    <= 1'b0;
               addr_q  <= pc_d;
               state_q <= ST_FETCH;
            end
            ST_LOAD1: begin
               if (mem_to_core_ready) begin
                  ld_data_q <= mem_to_core_data;
                  req_q     <= 1'b0;
                  state_q   <= ST_LOAD2;
               end
            end
            ST_STORE1: begin
               if (mem_to_core_ready) begin
                  req_q   <= 1'b0;
                  we_q    <= 1'b0;
                  wdata_q <= '0;
                  state_q <= ST_STORE2;
               end
            end
            ST_LOAD2, ST_STORE2: begin
               pc_q    <= pc_inc;
               req_q   <= 1'b1;
               we_q    <= 1'b0;
               addr_q  <= pc_inc;
               state_q <= ST_FETCH;
            end
            ST_HALT: begin
               req_q <= 1'b0;
               we_q  <= 1'b0;
            end
            default: state_q <= ST_HALT;
         endcase
      end
   end

   assign core_to_mem_req          = req_q;
   assign core_to_mem_addr         = addr_q;
   assign core_to_mem_data         = wdata_q;
   assign core_to_mem_write_enable = we_q;
   assign halted                   = halted_q;
   assign dbg_pc                   = pc_q;

endmodule

// File: tb/tb_mc_core.sv
// Self-checking bench for mc_core: a memory model records every completed bus
// transaction; each test pushes the expected transactions and compares them.
module tb_mc_core;

   localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, ADDI = 5'd2, SHLLI = 5'd3, SHRLI = 5'd4;
   localparam logic [4:0] JUMP = 5'd5, JUMPLI = 5'd6, JUMPL = 5'd7, JUMPG = 5'd8, JUMPE = 5'd9;
   localparam logic [4:0] JUMPNE = 5'd10, CMP = 5'd11, RET = 5'd12, LOAD = 5'd13, LOADI = 5'd14;
   localparam logic [4:0] STORE = 5'd15, MOV = 5'd16;
   localparam logic [15:0] HALT_INSTR = 16'hF800;
   localparam logic [15:0] NOP_INSTR  = 16'h8000;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [15:0] data;
      int          cyc;
      int          hold;
      logic        stable;
   } txn_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] mem_to_core_data = '0;
   logic        mem_to_core_ready = 1'b0;
   logic        core_to_mem_req;
   logic [15:0] core_to_mem_addr;
   logic [15:0] core_to_mem_data;
   logic        core_to_mem_write_enable;
   logic        halted;
   logic [15:0] dbg_pc;

   txn_t        exp_q[$];
   txn_t        obs_q[$];
   logic [15:0] mem [256];
   int          wait_cfg = 0;
   bit          stall_wr = 1'b0;
   int          cyc = 0;
   int          hold = 0;
   logic [15:0] h_addr, h_data;
   logic        h_we, h_stable;
   int          checks = 0;
   int          errors = 0;

   mc_core #(
      .DATA_W   (16),
      .ADDR_W   (16),
      .RESET_PC (16'd0)
   ) dut (
      .clk                      (clk),
      .rst_n                    (rst_n),
      .mem_to_core_data         (mem_to_core_data),
      .mem_to_core_ready        (mem_to_core_ready),
      .core_to_mem_req          (core_to_mem_req),
      .core_to_mem_addr         (core_to_mem_addr),
      .core_to_mem_data         (core_to_mem_data),
      .core_to_mem_write_enable (core_to_mem_write_enable),
      .halted                   (halted),
      .dbg_pc                   (dbg_pc)
   );

   always #5 clk = ~clk;

   // Memory model: answers after wait_cfg stall cycles, tracks request stability.
   always @(negedge clk) begin
      cyc++;
      if (rst_n && core_to_mem_req) begin
         if (hold == 0) begin
            h_addr = core_to_mem_addr; h_we = core_to_mem_write_enable;
            h_data = core_to_mem_data; h_stable = 1'b1;
         end else if (h_addr !== core_to_mem_addr || h_we !== core_to_mem_write_enable ||
                      h_data !== core_to_mem_data) begin
            h_stable = 1'b0;
         end
         hold++;
         if (hold > wait_cfg && !(stall_wr && core_to_mem_write_enable)) begin
            mem_to_core_ready = 1'b1;
            mem_to_core_data  = mem[core_to_mem_addr[7:0]];
            if (core_to_mem_write_enable) mem[core_to_mem_addr[7:0]] = core_to_mem_data;
            obs_q.push_back('{core_to_mem_write_enable, core_to_mem_addr, core_to_mem_data,
                              cyc, hold, h_stable});
            $display("txn cyc=%0d we=%0b addr=%h data=%h hold=%0d", cyc,
                     core_to_mem_write_enable, core_to_mem_addr, core_to_mem_data, hold);
            hold = 0;
         end else begin
            mem_to_core_ready = 1'b0;
         end
      end else begin
         mem_to_core_ready = 1'b0;
         hold = 0;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] ins(input logic [4:0] op, input logic [2:0] rd, input logic [7:0] imm);
      return {op, rd, imm};
   endfunction

   function automatic logic [15:0] rr(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs);
      return {op, rd, rs, 5'b0};
   endfunction

   task automatic push_txn(input logic we, input logic [15:0] a, input logic [15:0] d);
      exp_q.push_back('{we, a, d, 0, 0, 1'b1});
   endtask

   task automatic push_fetches(input int first, input int last);
      for (int a = first; a <= last; a++) push_txn(1'b0, 16'(a), 16'h0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      wait_cfg = 0;
      stall_wr = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = HALT_INSTR;
      exp_q.delete();
      obs_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_halt(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (halted) begin ok = 1'b1; break; end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      int n;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      checks++; if (core_to_mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", core_to_mem_req); end
      checks++; if (core_to_mem_write_enable !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", core_to_mem_write_enable); end
      checks++; if (core_to_mem_data !== 16'h0) begin errors++; $display("FAIL reset_data got %h exp 0000", core_to_mem_data); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
      checks++; if (dbg_pc !== 16'h0) begin errors++; $display("FAIL reset_pc got %h exp 0000", dbg_pc); end
      do_reset();
      n = 0;
      while (obs_q.size() == 0 && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (obs_q.size() == 0) begin
         errors++; $display("FAIL reset_first_fetch got none exp addr 0000");
      end else if (obs_q[0].addr !== 16'h0 || obs_q[0].we !== 1'b0) begin
         errors++; $display("FAIL reset_first_fetch got addr=%h we=%b exp addr=0000 we=0", obs_q[0].addr, obs_q[0].we);
      end
   endtask

   task automatic test_alu_seq();
      txn_t e, o;
      bit ok;
      int n, c0, c3;
      do_reset();
      mem[0] = ins(ADDI, 3'd1, 8'd5);
      mem[1] = ins(ADDI, 3'd2, 8'd3);
      mem[2] = rr(SUB, 3'd1, 3'd2);
      mem[3] = ins(JUMPE, 3'd0, 8'd2);
      mem[4] = ins(JUMPL, 3'd0, 8'd2);
      mem[5] = rr(STORE, 3'd1, 3'd0);
      push_fetches(0, 5); push_txn(1'b1, 16'h0, 16'd2); push_fetches(6, 6);
      wait_halt(200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL alu_halt got running exp halted"); end
      n = 0; c0 = 0; c3 = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); checks++;
         if (obs_q.size() == 0) begin errors++; $display("FAIL alu_txn%0d got none exp we=%b addr=%h data=%h", n, e.we, e.addr, e.data); end
         else begin
            o = obs_q.pop_front();
            if (n == 0) c0 = o.cyc;
            if (n == 3) c3 = o.cyc;
            if (o.we !== e.we || o.addr !== e.addr || o.data !== e.data) begin
               errors++; $display("FAIL alu_txn%0d got we=%b addr=%h data=%h exp we=%b addr=%h data=%h", n, o.we, o.addr, o.data, e.we, e.addr, e.data);
            end
         end
         n++;
      end
      checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL alu_extra got %0d extra txns exp 0", obs_q.size()); end
      checks++; if (c3 - c0 != 9) begin errors++; $display("FAIL alu_cycles got %0d exp 9", c3 - c0); end
   endtask

   task automatic test_shift();
      txn_t e, o;
      bit ok;
      int n;
      do_reset();
      mem[0]  = ins(ADDI, 3'd1, 8'd127);
      mem[1]  = ins(ADDI, 3'd1, 8'd127);
      mem[2]  = ins(SHLLI, 3'd1, 8'd8);
      mem[3]  = rr(STORE, 3'd1, 3'd0);
      mem[4]  = ins(SHRLI, 3'd1, 8'd4);
      mem[5]  = rr(STORE, 3'd1, 3'd0);
      mem[6]  = ins(SHLLI, 3'd1, 8'd31);
      mem[7]  = rr(STORE, 3'd1, 3'd0);
      mem[8]  = ins(ADDI, 3'd2, 8'hFF);
      mem[9]  = rr(STORE, 3'd2, 3'd0);
      mem[10] = ins(SHRLI, 3'd2, 8'd16);
      mem[11] = rr(STORE, 3'd2, 3'd0);
      push_fetches(0, 3);   push_txn(1'b1, 16'h0, 16'hFE00);
      push_fetches(4, 5);   push_txn(1'b1, 16'h0, 16'h0FE0);
      push_fetches(6, 7);   push_txn(1'b1, 16'h0, 16'h0000);
      push_fetches(8, 9);   push_txn(1'b1, 16'h0, 16'hFFFF);
      push_fetches(10, 11); push_txn(1'b1, 16'h0, 16'h0000);
      push_fetches(12, 12);
      wait_halt(300, ok);
      checks++; if (!ok) begin errors++; $display("FAIL shift_halt got running exp halted"); end
      n = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); checks++;
         if (obs_q.size() == 0) begin errors++; $display("FAIL shift_txn%0d got none exp we=%b addr=%h data=%h", n, e.we, e.addr, e.data); end
         else begin
            o = obs_q.pop_front();
            if (o.we !== e.we || o.addr !== e.addr || o.data !== e.data) begin
               errors++; $display("FAIL shift_txn%0d got we=%b addr=%h data=%h exp we=%b addr=%h data=%h", n, o.we, o.addr, o.data, e.we, e.addr, e.data);
            end
         end
         n++;
      end
      checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL shift_extra got %0d extra txns exp 0", obs_q.size()); end
   endtask

   task automatic test_branch();
      txn_t e, o;
      bit ok;
      int n;
      for (int v = 0; v < 2; v++) begin
         do_reset();
         for (int a = 0; a < 9; a++) mem[a] = NOP_INSTR;
         mem[9]  = rr(CMP, 3'd1, 3'd1);
         mem[10] = ins((v == 0) ? JUMPE : JUMPNE, 3'd0, 8'd4);
         push_fetches(0, 10);
         push_fetches((v == 0) ? 15 : 11, (v == 0) ? 15 : 11);
         wait_halt(300, ok);
         checks++; if (!ok) begin errors++; $display("FAIL branch%0d_halt got running exp halted", v); end
         n = 0;
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL branch%0d_txn%0d got none exp addr=%h", v, n, e.addr); end
            else begin
               o = obs_q.pop_front();
               if (o.we !== e.we || o.addr !== e.addr || o.data !== e.data) begin
                  errors++; $display("FAIL branch%0d_txn%0d got we=%b addr=%h exp we=%b addr=%h", v, n, o.we, o.addr, e.we, e.addr);
               end
            end
            n++;
         end
         checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL branch%0d_extra got %0d extra txns exp 0", v, obs_q.size()); end
      end
   endtask

   task automatic test_load_wait();
      txn_t e, o;
      bit ok;
      int n;
      do_reset();
      wait_cfg = 3;
      mem[0] = ins(ADDI, 3'd2, 8'h40);
      mem[1] = rr(LOAD, 3'd3, 3'd2);
      mem[2] = rr(STORE, 3'd3, 3'd0);
      mem[3] = ins(LOADI, 3'd4, 8'h41);
      mem[4] = rr(STORE, 3'd4, 3'd0);
      mem[8'h40] = 16'hBEEF;
      mem[8'h41] = 16'h1234;
      push_fetches(0, 1); push_txn(1'b0, 16'h0040, 16'h0);
      push_fetches(2, 2); push_txn(1'b1, 16'h0000, 16'hBEEF);
      push_fetches(3, 3); push_txn(1'b0, 16'h0041, 16'h0);
      push_fetches(4, 4); push_txn(1'b1, 16'h0000, 16'h1234);
      push_fetches(5, 5);
      wait_halt(400, ok);
      checks++; if (!ok) begin errors++; $display("FAIL load_halt got running exp halted"); end
      n = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); checks++;
         if (obs_q.size() == 0) begin errors++; $display("FAIL load_txn%0d got none exp we=%b addr=%h data=%h", n, e.we, e.addr, e.data); end
         else begin
            o = obs_q.pop_front();
            if (o.we !== e.we || o.addr !== e.addr || o.data !== e.data || o.hold != 4 || o.stable !== 1'b1) begin
               errors++; $display("FAIL load_txn%0d got we=%b addr=%h data=%h hold=%0d stable=%b exp we=%b addr=%h data=%h hold=4 stable=1",
                                  n, o.we, o.addr, o.data, o.hold, o.stable, e.we, e.addr, e.data);
            end
         end
         n++;
      end
      checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL load_extra got %0d extra txns exp 0", obs_q.size()); end
   endtask

   task automatic test_link();
      txn_t e, o;
      bit ok;
      int n;
      do_reset();
      mem[0]  = ins(JUMPLI, 3'd0, 8'd19);
      mem[20] = ins(JUMPLI, 3'd0, 8'hFE);
      mem[19] = ins(RET, 3'd0, 8'd0);
      mem[21] = rr(STORE, 3'd7, 3'd0);
      push_fetches(0, 0); push_fetches(20, 20); push_fetches(19, 19); push_fetches(21, 21);
      push_txn(1'b1, 16'h0, 16'd21); push_fetches(22, 22);
      wait_halt(200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL link_halt got running exp halted"); end
      n = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); checks++;
         if (obs_q.size() == 0) begin errors++; $display("FAIL link_txn%0d got none exp we=%b addr=%h data=%h", n, e.we, e.addr, e.data); end
         else begin
            o = obs_q.pop_front();
            if (o.we !== e.we || o.addr !== e.addr || o.data !== e.data) begin
               errors++; $display("FAIL link_txn%0d got we=%b addr=%h data=%h exp we=%b addr=%h data=%h", n, o.we, o.addr, o.data, e.we, e.addr, e.data);
            end
         end
         n++;
      end
      checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL link_extra got %0d extra txns exp 0", obs_q.size()); end
   endtask

   task automatic test_misc();
      txn_t e, o;
      bit ok;
      int n;
      do_reset();
      mem[0]  = ins(ADDI, 3'd1, 8'd7);
      mem[1]  = rr(MOV, 3'd2, 3'd1);
      mem[2]  = rr(ADD, 3'd2, 3'd1);
      mem[3]  = rr(STORE, 3'd2, 3'd0);
      mem[4]  = ins(ADDI, 3'd3, 8'd10);
      mem[5]  = rr(JUMP, 3'd0, 3'd3);
      mem[10] = rr(CMP, 3'd2, 3'd1);
      mem[11] = ins(JUMPG, 3'd0, 8'd2);
      mem[14] = ins(JUMPL, 3'd0, 8'd2);
      push_fetches(0, 3); push_txn(1'b1, 16'h0, 16'd14);
      push_fetches(4, 5); push_fetches(10, 11); push_fetches(14, 15);
      wait_halt(300, ok);
      checks++; if (!ok) begin errors++; $display("FAIL misc_halt got running exp halted"); end
      n = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); checks++;
         if (obs_q.size() == 0) begin errors++; $display("FAIL misc_txn%0d got none exp we=%b addr=%h data=%h", n, e.we, e.addr, e.data); end
         else begin
            o = obs_q.pop_front();
            if (o.we !== e.we || o.addr !== e.addr || o.data !== e.data) begin
               errors++; $display("FAIL misc_txn%0d got we=%b addr=%h data=%h exp we=%b addr=%h data=%h", n, o.we, o.addr, o.data, e.we, e.addr, e.data);
            end
         end
         n++;
      end
      checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL misc_extra got %0d extra txns exp 0", obs_q.size()); end
   endtask

   task automatic test_halt_reset();
      txn_t e, o;
      bit ok, seen;
      int n, req_seen;
      // Illegal opcode at address 0 (memory is pre-filled with it).
      do_reset();
      push_fetches(0, 0);
      wait_halt(50, ok);
      checks++; if (!ok) begin errors++; $display("FAIL halt_state got running exp halted"); end
      req_seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (core_to_mem_req !== 1'b0) req_seen++;
      end
      checks++; if (req_seen != 0 || halted !== 1'b1) begin errors++; $display("FAIL halt_quiet got req_cycles=%0d halted=%b exp 0 1", req_seen, halted); end
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() != 1) begin errors++; $display("FAIL halt_txn got %0d txns exp 1", obs_q.size()); end
      else begin
         o = obs_q.pop_front();
         if (o.addr !== e.addr || o.we !== e.we) begin errors++; $display("FAIL halt_txn got addr=%h we=%b exp addr=%h we=0", o.addr, o.we, e.addr); end
      end
      // Reset while a store is being held off by the memory.
      do_reset();
      stall_wr = 1'b1;
      mem[0] = ins(ADDI, 3'd1, 8'd9);
      mem[1] = rr(STORE, 3'd1, 3'd0);
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (core_to_mem_req === 1'b1 && core_to_mem_write_enable === 1'b1) seen = 1'b1;
      end
      checks++; if (!seen) begin errors++; $display("FAIL store_seen got none exp held store"); end
      repeat (3) @(negedge clk);
      checks++;
      if (core_to_mem_req !== 1'b1 || core_to_mem_data !== 16'd9 || core_to_mem_addr !== 16'h0) begin
         errors++; $display("FAIL store_held got req=%b addr=%h data=%h exp 1 0000 0009", core_to_mem_req, core_to_mem_addr, core_to_mem_data);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (core_to_mem_req !== 1'b0 || core_to_mem_write_enable !== 1'b0 || core_to_mem_data !== 16'h0 || dbg_pc !== 16'h0) begin
         errors++; $display("FAIL store_reset got req=%b we=%b data=%h pc=%h exp 0 0 0000 0000",
                            core_to_mem_req, core_to_mem_write_enable, core_to_mem_data, dbg_pc);
      end
      obs_q.delete();
      @(negedge clk);
      stall_wr = 1'b0;
      rst_n = 1'b1;
      push_fetches(0, 1); push_txn(1'b1, 16'h0, 16'd9); push_fetches(2, 2);
      wait_halt(200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rerun_halt got running exp halted"); end
      n = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); checks++;
         if (obs_q.size() == 0) begin errors++; $display("FAIL rerun_txn%0d got none exp we=%b addr=%h data=%h", n, e.we, e.addr, e.data); end
         else begin
            o = obs_q.pop_front();
            if (o.we !== e.we || o.addr !== e.addr || o.data !== e.data) begin
               errors++; $display("FAIL rerun_txn%0d got we=%b addr=%h data=%h exp we=%b addr=%h data=%h", n, o.we, o.addr, o.data, e.we, e.addr, e.data);
            end
         end
         n++;
      end
      checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rerun_extra got %0d extra txns exp 0", obs_q.size()); end
   endtask

   initial begin
      test_reset();
      test_alu_seq();
      test_shift();
      test_branch();
      test_load_wait();
      test_link();
      test_misc();
      test_halt_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
